frame_sequencer: RTL

Frame-rate scheduler for the audio channel datapath (pulse 1, pulse 2, triangle, mixer, PWM). It divides the system clock into sequencer steps and emits one-cycle quarter-frame and half-frame strobes. Channel envelope, sweep and length logic consume these strobes. It also produces a frame-start strobe and a sticky frame interrupt. It supports a 4-step mode and a 5-step mode, selectable at run time.

---
 rtl/frame_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame-rate scheduler for the audio channels. It divides clk into sequencer
// steps and emits quarter-frame, half-frame and frame-start strobes. It also
// keeps a sticky frame interrupt. The 4-step or 5-step sequence is selected
// at run time.
//
// state  | meaning
// -------+------------------------------------------------------------
// STEP_0 | first step of the frame (completes with quarter)
// STEP_1 | second step (completes with quarter + half)
// STEP_2 | third step (completes with quarter)
// STEP_3 | 4-step: last step, q+h+irq, wraps; 5-step: silent step
// STEP_4 | 5-step only: last step, quarter + half, wraps
module frame_sequencer #(
    parameter int TICK_DIV = 104167,
    parameter int CNT_W    = 17
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_mode,
    input  logic       i_mode_valid,
    input  logic       i_irq_inhibit,
    input  logic       i_irq_ack,
    output logic       o_quarter_frame,
    output logic       o_half_frame,
    output logic       o_frame_pulse,
    output logic       o_irq,
    output logic [2:0] o_step
);

    typedef enum logic [2:0] {
        STEP_0 = 3'd0,
        STEP_1 = 3'd1,
        STEP_2 = 3'd2,
        STEP_3 = 3'd3,
        STEP_4 = 3'd4
    } step_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    step_t            step_q, step_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             mode_q, mode_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;
    logic             frame_q, frame_d;
    logic             irq_q, irq_d;
    logic             irq_set;
    logic             tick;

    assign tick = (presc_q == TICK_LAST);

    // State register; reset abandons any in-progress step and clears all strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q    <= STEP_0;
            presc_q   <= '0;
            mode_q    <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
            frame_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            step_q    <= step_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
            frame_q   <= frame_d;
            irq_q     <= irq_d;
        end
    end

    // Next-state and strobe decode; a mode write takes priority over a coincident tick.
    always_comb begin
        presc_d   = presc_q + CNT_W'(1);
        step_d    = step_q;
        mode_d    = mode_q;
        quarter_d = 1'b0;
        half_d    = 1'b0;
        frame_d   = 1'b0;
        irq_set   = 1'b0;

        if (i_mode_valid) begin
            mode_d    = i_mode;
            presc_d   = '0;
            step_d    = STEP_0;
            // Entering 5-step mode clocks the channels immediately.
            quarter_d = i_mode;
            half_d    = i_mode;
        end else if (tick) begin
            presc_d = '0;
            case (step_q)
                STEP_0: begin
                    quarter_d = 1'b1;
                    step_d    = STEP_1;
                end
                STEP_1: begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                    step_d    = STEP_2;
                end
                STEP_2: begin
                    quarter_d = 1'b1;
                    step_d    = STEP_3;
                end
                STEP_3: begin
                    if (mode_q) begin
                        step_d = STEP_4;
                    end else begin
                        quarter_d = 1'b1;
                        half_d    = 1'b1;
                        frame_d   = 1'b1;
                        irq_set   = 1'b1;
                        step_d    = STEP_0;
                    end
                end
                STEP_4: begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                    frame_d   = 1'b1;
                    step_d    = STEP_0;
                end
                default: step_d = STEP_0;
            endcase
        end

        // Inhibit beats set, and set beats a same-cycle ack.
        if (i_irq_inhibit) begin
            irq_d = 1'b0;
        end else if (irq_set) begin
            irq_d = 1'b1;
        end else if (i_irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    assign o_quarter_frame = quarter_q;
    assign o_half_frame    = half_q;
    assign o_frame_pulse   = frame_q;
    assign o_irq           = irq_q;
    assign o_step          = 3'(step_q);

endmodule
